mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//   Round-robin arbiter sharing one memory port among N_REQ clients.
//   Clients and the memory both use a 4-phase req/ack handshake.
//   Sits between the client controllers and the memory-side handshake controller.
//   Serialises accesses: exactly one transaction is outstanding at the memory at any time.
// PARAMETERS
//   N_REQ    4    number of clients (>=2)
//   AW       16   address width
//   DW       32   data width
//   TIMEOUT  255  memory-ack watchdog limit in cycles (only with MEM_ARB_TIMEOUT_EN)
// PORTS
//   clk_i        in   1         single clock; all logic on posedge
//   rst_i        in   1         synchronous, active-high reset
//   cli_req_i    in   N_REQ     per-client request (4-phase)
//   cli_ack_o    out  N_REQ     per-client acknowledge (4-phase)
//   cli_we_i     in   N_REQ     per-client write enable
//   cli_addr_i   in   N_REQ*AW  packed client addresses; client k = [k*AW +: AW]
//   cli_wdata_i  in   N_REQ*DW  packed client write data
//   cli_rdata_o  out  DW        read data, valid while the granted client's ack is high
//   mem_req_o    out  1         memory request
//   mem_ack_i    in   1         memory acknowledge; synchronous to clk_i, no synchroniser
//   mem_we_o     out  1         memory write enable
//   mem_addr_o   out  AW        memory address
//   mem_wdata_o  out  DW        memory write data
//   mem_rdata_i  in   DW        memory read data
//   grant_o      out  N_REQ     one-hot current owner; 0 in IDLE
//   busy_o       out  1         1 in any state other than IDLE
//   timeout_o    out  1         1-cycle pulse on watchdog abort (port exists only with macro)
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; last_grant = N_REQ-1, so client 0 wins first.
//   Reset asserted mid-transaction: immediate return to IDLE; in-flight transfer is dropped.
//   Every output is registered.
//   FSM:
//   - IDLE: arbitrates only when |cli_req_i and mem_ack_i==0.
//     * Winner: first set request scanning from last_grant+1 upward, with wrap-around.
//     * Latches the winner's index, we, addr and wdata into the mem_* registers.
//     * Goes to REQ; mem_req_o rises 1 cycle after the request is sampled.
//   - REQ: holds mem_req_o=1.
//     * On mem_ack_i==1: cli_rdata_o <= mem_rdata_i; mem_req_o <= 0; go to REL.
//   - REL: waits for mem_ack_i==0, then sets cli_ack_o[idx] <= 1 and goes to ACK.
//   - ACK: holds cli_ack_o[idx]=1 until cli_req_i[idx]==0.
//     * Then ack <= 0, last_grant <= idx, go to IDLE.
//   Latency and throughput:
//     * Minimum client req -> client ack is 4 cycles when memory acks in 1 cycle.
//     * The grant is not re-arbitrated until the client's full 4-phase cycle completes.
//   Boundary conditions:
//     * Client requests changing while not in IDLE do not affect the current owner.
//     * Owner drops req before its ack (protocol violation): transfer completes; ack is
//       a single-cycle pulse.
//     * Write transactions: cli_rdata_o is still loaded from mem_rdata_i (don't-care).
//     * mem_addr_o, mem_we_o and mem_wdata_o stay stable from REQ entry until IDLE.
//     * One requester only: it is granted repeatedly with no idle penalty beyond IDLE's one cycle.
// CONFIGURATION
//   MEM_ARB_TIMEOUT_EN defined:
//     * Cycle counter of width $clog2(TIMEOUT+1); clears on entry to REQ.
//     * The counter runs through REQ and REL.
//     * When it reaches TIMEOUT: mem_req_o <= 0, cli_rdata_o <= '1, timeout_o pulses for 1 cycle.
//     * The FSM then goes straight to ACK, so the client handshake still completes.
//   Undefined: no counter and no timeout_o port; REQ and REL wait indefinitely.
// STRUCTURE
//   Package mem_arb_pkg holds:
//     * typedef enum logic [1:0] {IDLE, REQ, REL, ACK} arb_state_t;
//     * localparam helpers for the index width, $clog2(N_REQ).
//   Sub-module rr_pick (N_REQ): combinational round-robin picker.
//     * Inputs: req vector, last_grant. Outputs: valid and the winner index.
// TESTING
//   1. Single client: N_REQ=4, client 2 reads addr 0x0010, memory acks after 3 cycles
//      with 0xDEADBEEF.
//      -> mem_addr_o=0x0010, cli_ack_o=4'b0100, cli_rdata_o=0xDEADBEEF.
//   2. All 4 clients request continuously from reset.
//      -> grant order 0,1,2,3,0; no client is granted twice before the others.
//   3. Client 1 writes 0x0000_00A5 to 0x00FF.
//      -> mem_we_o=1, mem_wdata_o=0xA5 held stable from mem_req_o rise until mem_ack_i falls.
//   4. rst_i for 1 cycle while in REQ.
//      -> next cycle all outputs 0, busy_o=0; next arbitration starts from client 0.
//   5. mem_ack_i held high at reset release with cli_req_i=4'b0001.
//      -> no grant until mem_ack_i falls; grant on the following cycle.
//   6. MEM_ARB_TIMEOUT_EN, TIMEOUT=8, memory never acks.
//      -> timeout_o pulses 8 cycles after REQ entry; cli_rdata_o=32'hFFFF_FFFF; client is acked.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared state encoding and index-width helper for the round-robin memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, REQ, REL, ACK} arb_state_t;

    localparam int MIN_IDX_W = 1;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : MIN_IDX_W;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request above last_grant, wrapping around.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]            req,
    input  logic [idx_w(N_REQ)-1:0]     last_grant,
    output logic                        valid,
    output logic [idx_w(N_REQ)-1:0]     idx
);

    localparam int IW = idx_w(N_REQ);

    logic [IW-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IW'((int'(last_grant) + i) % N_REQ);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising N_REQ 4-phase clients onto one 4-phase memory port.
// Optional memory-ack watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int AW      = 16,
    parameter int DW      = 32
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_REQ-1:0]      cli_req_i,
    output logic [N_REQ-1:0]      cli_ack_o,
    input  logic [N_REQ-1:0]      cli_we_i,
    input  logic [N_REQ*AW-1:0]   cli_addr_i,
    input  logic [N_REQ*DW-1:0]   cli_wdata_i,
    output logic [DW-1:0]         cli_rdata_o,
    output logic                  mem_req_o,
    input  logic                  mem_ack_i,
    output logic                  mem_we_o,
    output logic [AW-1:0]         mem_addr_o,
    output logic [DW-1:0]         mem_wdata_o,
    input  logic [DW-1:0]         mem_rdata_i,
    output logic [N_REQ-1:0]      grant_o,
    output logic                  busy_o
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    output logic                  timeout_o
`endif
);

    localparam int IW = idx_w(N_REQ);

    arb_state_t       state, state_d;
    logic [IW-1:0]    idx, idx_d;
    logic [IW-1:0]    last_grant, last_grant_d;
    logic             pick_valid;
    logic [IW-1:0]    pick_idx;

    logic [N_REQ-1:0] cli_ack_d, grant_d;
    logic [DW-1:0]    cli_rdata_d, mem_wdata_d;
    logic [AW-1:0]    mem_addr_d;
    logic             mem_req_d, mem_we_d, busy_d;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0]    wd_cnt, wd_cnt_d, wd_inc;
    logic             wd_expired, abort, timeout_d;

    assign wd_inc     = wd_cnt + CW'(1);
    assign wd_expired = (wd_inc == CW'(TIMEOUT));
`endif

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req        (cli_req_i),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .idx        (pick_idx)
    );

    always_comb begin
        state_d      = state;
        idx_d        = idx;
        last_grant_d = last_grant;
        cli_ack_d    = cli_ack_o;
        cli_rdata_d  = cli_rdata_o;
        mem_req_d    = mem_req_o;
        mem_we_d     = mem_we_o;
        mem_addr_d   = mem_addr_o;
        mem_wdata_d  = mem_wdata_o;
        grant_d      = grant_o;
        busy_d       = busy_o;
`ifdef MEM_ARB_TIMEOUT_EN
        wd_cnt_d     = wd_cnt;
        abort        = 1'b0;
        timeout_d    = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                // A lingering memory ack from a previous cycle blocks arbitration.
                if (pick_valid && !mem_ack_i) begin
                    state_d     = REQ;
                    idx_d       = pick_idx;
                    mem_we_d    = cli_we_i[pick_idx];
                    mem_addr_d  = cli_addr_i[int'(pick_idx)*AW +: AW];
                    mem_wdata_d = cli_wdata_i[int'(pick_idx)*DW +: DW];
                    mem_req_d   = 1'b1;
                    grant_d     = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    busy_d      = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                    wd_cnt_d    = '0;
`endif
                end
            end
            REQ: begin
                if (mem_ack_i) begin
                    cli_rdata_d = mem_rdata_i;
                    mem_req_d   = 1'b0;
                    state_d     = REL;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else begin
                    abort = wd_expired;
                end
`endif
            end
            REL: begin
                if (!mem_ack_i) begin
                    cli_ack_d[idx] = 1'b1;
                    state_d        = ACK;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else begin
                    abort = wd_expired;
                end
`endif
            end
            ACK: begin
                if (!cli_req_i[idx]) begin
                    cli_ack_d    = '0;
                    last_grant_d = idx;
                    grant_d      = '0;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef MEM_ARB_TIMEOUT_EN
        if (state == REQ || state == REL) begin
            wd_cnt_d = wd_inc;
        end
        // Abort still completes the client handshake, with all-ones as read data.
        if (abort) begin
            mem_req_d      = 1'b0;
            cli_rdata_d    = '1;
            timeout_d      = 1'b1;
            cli_ack_d[idx] = 1'b1;
            state_d        = ACK;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            idx         <= '0;
            last_grant  <= IW'(N_REQ - 1);
            cli_ack_o   <= '0;
            cli_rdata_o <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            grant_o     <= '0;
            busy_o      <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            wd_cnt      <= '0;
            timeout_o   <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            last_grant  <= last_grant_d;
            cli_ack_o   <= cli_ack_d;
            cli_rdata_o <= cli_rdata_d;
            mem_req_o   <= mem_req_d;
            mem_we_o    <= mem_we_d;
            mem_addr_o  <= mem_addr_d;
            mem_wdata_o <= mem_wdata_d;
            grant_o     <= grant_d;
            busy_o      <= busy_d;
`ifdef MEM_ARB_TIMEOUT_EN
            wd_cnt      <= wd_cnt_d;
            timeout_o   <= timeout_d;
`endif
        end
    end

endmodule
